// File: rtl/lut7_reconfig_ctrl_if.sv
// rtl/lut7_reconfig_ctrl_if.sv - lookup and configuration-load signal bundle for lut7_reconfig_ctrl
// The master drives lookups and load commands; the slave is the controller.
interface lut7_reconfig_ctrl_if #(
   parameter int WORD_W = 32
);
   logic              CE;
   logic [6:0]        ADR;
   logic              O;
   logic              CFG_START;
   logic              CFG_COMMIT;
   logic              CFG_ABORT;
   logic [WORD_W-1:0] DIN;
   logic              DIN_VLD;
   logic              DIN_RDY;
   logic              BUSY;
   logic              DONE;
   logic              ERR;

   modport master (
      output CE, ADR, CFG_START, CFG_COMMIT, CFG_ABORT, DIN, DIN_VLD,
      input  O, DIN_RDY, BUSY, DONE, ERR
   );

   modport slave (
      input  CE, ADR, CFG_START, CFG_COMMIT, CFG_ABORT, DIN, DIN_VLD,
      output O, DIN_RDY, BUSY, DONE, ERR
   );
endinterface

// File: rtl/lut7_reconfig_ctrl.sv
// rtl/lut7_reconfig_ctrl.sv - 7-input LUT with shadow-table load and atomic commit
// The lookup path reads only the active table, so a load never disturbs evaluation.
module lut7_reconfig_ctrl #(
   parameter logic [127:0] INIT   = 128'h0,
   parameter int           WORD_W = 32
) (
   input logic                 CLK,
   input logic                 RST,
   lut7_reconfig_ctrl_if.slave bus
);
   localparam int NWORDS = 128 / WORD_W;
   localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ARMED = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [127:0]     shadow_q, shadow_d;
   logic [127:0]     active_q, active_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             o_q;
   logic             word_take;
   logic [6:0]       word_base;

   assign word_base = 7'(int'(cnt_q) * WORD_W);

   // Command priority: abort, then commit, then start, then the data word.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      word_take = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.CFG_COMMIT) begin
               err_d = 1'b1;
            end else if (bus.CFG_START) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end

         ST_LOAD: begin
            if (bus.CFG_ABORT) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               if (bus.CFG_COMMIT) begin
                  err_d = 1'b1;
               end
               // A restart drops any word presented in the same cycle.
               if (!bus.CFG_COMMIT && bus.CFG_START) begin
                  cnt_d = '0;
               end else begin
                  word_take = bus.DIN_VLD;
               end
               if (word_take) begin
                  shadow_d[word_base +: WORD_W] = bus.DIN;
                  if (cnt_q == LAST_WORD) begin
                     cnt_d   = '0;
                     state_d = ST_ARMED;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         end

         ST_ARMED: begin
            if (bus.CFG_ABORT) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (bus.CFG_COMMIT) begin
               active_d = shadow_q;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end else if (bus.CFG_START) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         active_q <= INIT;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Reads active_q before the commit edge updates it, so O never mixes tables.
   always_ff @(posedge CLK) begin
      if (RST) begin
         o_q <= 1'b0;
      end else if (bus.CE) begin
         o_q <= active_q[bus.ADR];
      end
   end

   assign bus.O       = o_q;
   assign bus.DIN_RDY = (state_q == ST_LOAD);
   assign bus.BUSY    = (state_q != ST_IDLE);
   assign bus.DONE    = done_q;
   assign bus.ERR     = err_q;
endmodule

// File: tb/tb_lut7_reconfig_ctrl.sv
// tb/tb_lut7_reconfig_ctrl.sv - scoreboard bench for lut7_reconfig_ctrl
// Stimulus pushes expected lookups and DONE/ERR pulse cycles; a monitor pops and compares.
module tb_lut7_reconfig_ctrl;
   localparam logic [127:0] INIT_T = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

   logic CLK;
   logic RST;
   lut7_reconfig_ctrl_if #(.WORD_W(32)) bus ();

   lut7_reconfig_ctrl #(
      .INIT   (INIT_T),
      .WORD_W (32)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   exp_o_q[$];
   int   done_q[$];
   int   err_q[$];
   logic lk_req = 1'b0;
   logic lk_pend = 1'b0;
   bit   e_o;

   function automatic void chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void chk_empty(input string name, input int sz);
      checks++;
      if (sz != 0) begin
         errors++;
         $display("FAIL %s: got %0d leftover entries expected 0", name, sz);
      end
   endfunction

   always @(posedge CLK) begin
      cyc     <= cyc + 1;
      lk_pend <= lk_req;
   end

   always @(negedge CLK) begin
      if (lk_pend) begin
         if (exp_o_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lookup_unscheduled: got O=%b with no expectation queued", bus.O);
         end else begin
            e_o = exp_o_q.pop_front();
            chk("lookup_O", bus.O, e_o);
         end
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
         void'(done_q.pop_front());
         chk("done_pulse", bus.DONE, 1'b1);
      end else if (bus.DONE) begin
         chk("done_unexpected", bus.DONE, 1'b0);
      end
      if (err_q.size() > 0 && err_q[0] == cyc) begin
         void'(err_q.pop_front());
         chk("err_pulse", bus.ERR, 1'b1);
      end else if (bus.ERR) begin
         chk("err_unexpected", bus.ERR, 1'b0);
      end
   end

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic lookup(input logic [6:0] a, input bit e);
      bus.ADR = a;
      lk_req  = 1'b1;
      exp_o_q.push_back(e);
      step();
      lk_req  = 1'b0;
   endtask

   task automatic pulse_start();
      bus.CFG_START = 1'b1;
      step();
      bus.CFG_START = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      chk("din_rdy_in_load", bus.DIN_RDY, 1'b1);
      bus.DIN     = w;
      bus.DIN_VLD = 1'b1;
      step();
      bus.DIN_VLD = 1'b0;
      step();
      chk("busy_during_load", bus.BUSY, 1'b1);
   endtask

   task automatic load4(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
      pulse_start();
      send_word(w0);
      send_word(w1);
      send_word(w2);
      send_word(w3);
      chk("din_rdy_armed", bus.DIN_RDY, 1'b0);
   endtask

   task automatic commit_ok();
      done_q.push_back(cyc + 1);
      bus.CFG_COMMIT = 1'b1;
      step();
      bus.CFG_COMMIT = 1'b0;
      chk("busy_after_commit", bus.BUSY, 1'b0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST            = 1'b1;
      bus.CE         = 1'b1;
      bus.ADR        = 7'd0;
      bus.CFG_START  = 1'b0;
      bus.CFG_COMMIT = 1'b0;
      bus.CFG_ABORT  = 1'b0;
      bus.DIN        = '0;
      bus.DIN_VLD    = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_O", bus.O, 1'b0);
      chk("rst_din_rdy", bus.DIN_RDY, 1'b0);
      chk("rst_busy", bus.BUSY, 1'b0);
      chk("rst_done", bus.DONE, 1'b0);
      chk("rst_err", bus.ERR, 1'b0);
      RST = 1'b0;
      lookup(7'd0, 1'b1);
      lookup(7'd127, 1'b1);
      lookup(7'd5, 1'b0);

      // Full load and commit
      load4(32'hFFFF_0000, 32'h0, 32'h0, 32'h1234_5678);
      chk("busy_armed", bus.BUSY, 1'b1);
      commit_ok();
      chk("din_rdy_idle", bus.DIN_RDY, 1'b0);
      lookup(7'd16, 1'b1);
      lookup(7'd15, 1'b0);
      lookup(7'd99, 1'b1);
      lookup(7'd0, 1'b0);
      lookup(7'd127, 1'b0);

      // Commit boundary: old bit0=1, new bit0=0
      load4(32'h0000_0001, 32'h0, 32'h0, 32'h0);
      commit_ok();
      lookup(7'd0, 1'b1);
      load4(32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0);
      bus.ADR = 7'd0;
      lk_req  = 1'b1;
      exp_o_q.push_back(1'b1);
      done_q.push_back(cyc + 1);
      bus.CFG_COMMIT = 1'b1;
      step();
      bus.CFG_COMMIT = 1'b0;
      exp_o_q.push_back(1'b0);
      step();
      lk_req = 1'b0;
      step();

      // Abort after two words
      pulse_start();
      send_word(32'hFFFF_FFFF);
      send_word(32'hFFFF_FFFF);
      bus.CFG_ABORT = 1'b1;
      step();
      bus.CFG_ABORT = 1'b0;
      step();
      chk("abort_busy", bus.BUSY, 1'b0);
      chk("abort_din_rdy", bus.DIN_RDY, 1'b0);
      lookup(7'd0, 1'b0);
      lookup(7'd40, 1'b0);
      lookup(7'd1, 1'b1);
      // CE low: O holds 1 while ADR points at a 0 bit
      bus.CE  = 1'b0;
      bus.ADR = 7'd0;
      lk_req  = 1'b1;
      exp_o_q.push_back(1'b1);
      step();
      lk_req = 1'b0;
      bus.CE = 1'b1;

      // Illegal commands
      err_q.push_back(cyc + 1);
      bus.CFG_COMMIT = 1'b1;
      step();
      bus.CFG_COMMIT = 1'b0;
      step();
      lookup(7'd0, 1'b0);
      lookup(7'd31, 1'b1);
      pulse_start();
      send_word(32'h0000_0100);
      chk("din_rdy_commit_in_load", bus.DIN_RDY, 1'b1);
      bus.DIN        = 32'h0;
      bus.DIN_VLD    = 1'b1;
      bus.CFG_COMMIT = 1'b1;
      err_q.push_back(cyc + 1);
      step();
      bus.DIN_VLD    = 1'b0;
      bus.CFG_COMMIT = 1'b0;
      step();
      chk("load_continues_busy", bus.BUSY, 1'b1);
      send_word(32'h0);
      send_word(32'h8000_0000);
      chk("armed_after_err_load", bus.DIN_RDY, 1'b0);
      commit_ok();
      lookup(7'd8, 1'b1);
      lookup(7'd1, 1'b0);
      lookup(7'd127, 1'b1);

      // ABORT + COMMIT together while armed
      load4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      bus.CFG_ABORT  = 1'b1;
      bus.CFG_COMMIT = 1'b1;
      step();
      bus.CFG_ABORT  = 1'b0;
      bus.CFG_COMMIT = 1'b0;
      step();
      chk("abort_commit_busy", bus.BUSY, 1'b0);
      lookup(7'd8, 1'b1);
      lookup(7'd50, 1'b0);
      lookup(7'd127, 1'b1);

      // Restart after three words, with a word presented on the restart cycle
      pulse_start();
      send_word(32'h1111_1111);
      send_word(32'h1111_1111);
      send_word(32'h1111_1111);
      bus.DIN       = 32'hDEAD_BEEF;
      bus.DIN_VLD   = 1'b1;
      bus.CFG_START = 1'b1;
      step();
      bus.DIN_VLD   = 1'b0;
      bus.CFG_START = 1'b0;
      step();
      send_word(32'h0000_0001);
      send_word(32'h0000_0002);
      send_word(32'h0000_0004);
      send_word(32'h0000_0008);
      chk("restart_armed", bus.DIN_RDY, 1'b0);
      commit_ok();
      lookup(7'd0, 1'b1);
      lookup(7'd33, 1'b1);
      lookup(7'd66, 1'b1);
      lookup(7'd99, 1'b1);
      lookup(7'd32, 1'b0);
      lookup(7'd4, 1'b0);
      lookup(7'd127, 1'b0);

      // Reset mid-load
      lookup(7'd0, 1'b1);
      pulse_start();
      send_word(32'hAAAA_AAAA);
      send_word(32'h5555_5555);
      RST = 1'b1;
      step();
      chk("midrst_O", bus.O, 1'b0);
      chk("midrst_din_rdy", bus.DIN_RDY, 1'b0);
      chk("midrst_busy", bus.BUSY, 1'b0);
      chk("midrst_done", bus.DONE, 1'b0);
      chk("midrst_err", bus.ERR, 1'b0);
      RST = 1'b0;
      lookup(7'd0, 1'b1);
      lookup(7'd127, 1'b1);
      lookup(7'd5, 1'b0);
      lookup(7'd33, 1'b0);

      step();
      step();
      step();
      chk_empty("lookup_queue", exp_o_q.size());
      chk_empty("done_queue", done_q.size());
      chk_empty("err_queue", err_q.size());
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
